// File: rtl/wave_sequencer.sv
// Playlist sequencer for the wave generator: steps func through up to 8 (waveform, dwell)
// entries, deferring each switch to a midscale crossing of the generator output.
//
//   state  | meaning
//   IDLE   | func parked at zero (101), waiting for start
//   RUN    | current entry driving func, dwell counter running down
//   ALIGN  | dwell expired, waiting for a midscale crossing or timeout
module wave_sequencer #(
    parameter int DWELL_W = 16,
    parameter int SYNC_TO = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [2:0]         wr_func,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [2:0]         cfg_last,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         wave_in,
    output logic [2:0]         func,
    output logic [2:0]         cur_idx,
    output logic               busy,
    output logic               step,
    output logic               done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_ALIGN = 2'd2;

    localparam logic [2:0] FUNC_ZERO = 3'b101;
    localparam int         TO_W      = (SYNC_TO > 1) ? $clog2(SYNC_TO) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYNC_TO - 1);

    logic [1:0]         state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [2:0]         nxt_idx;
    logic               msb_q;
    logic               crossing;
    logic               unused_wave;

    logic [2:0]         tbl_func  [8];
    logic [DWELL_W-1:0] tbl_dwell [8];

    assign crossing    = wave_in[7] != msb_q;
    assign unused_wave = ^wave_in[6:0];

    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                tbl_func[i]  <= FUNC_ZERO;
                tbl_dwell[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_func[wr_addr]  <= wr_func;
            tbl_dwell[wr_addr] <= wr_dwell;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msb_q <= 1'b0;
        end else begin
            msb_q <= wave_in[7];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            func      <= FUNC_ZERO;
            cur_idx   <= 3'd0;
            busy      <= 1'b0;
            step      <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= '0;
            to_cnt    <= '0;
            nxt_idx   <= 3'd0;
        end else begin
            step <= 1'b0;
            done <= 1'b0;
            if (stop) begin
                state <= S_IDLE;
                func  <= FUNC_ZERO;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        func <= FUNC_ZERO;
                        busy <= 1'b0;
                        if (start) begin
                            func      <= tbl_func[0];
                            cur_idx   <= 3'd0;
                            dwell_cnt <= dwell_load(tbl_dwell[0]);
                            busy      <= 1'b1;
                            state     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        if (dwell_cnt <= DWELL_W'(1)) begin
                            // cur_idx past cfg_last counts as the end of the list
                            if (cur_idx >= cfg_last && !loop) begin
                                state <= S_IDLE;
                                func  <= FUNC_ZERO;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state   <= S_ALIGN;
                                to_cnt  <= '0;
                                nxt_idx <= (cur_idx >= cfg_last) ? 3'd0 : 3'(cur_idx + 3'd1);
                            end
                        end
                    end
                    S_ALIGN: begin
                        if (crossing || to_cnt == TO_LAST) begin
                            func      <= tbl_func[nxt_idx];
                            cur_idx   <= nxt_idx;
                            dwell_cnt <= dwell_load(tbl_dwell[nxt_idx]);
                            step      <= 1'b1;
                            state     <= S_RUN;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        func  <= FUNC_ZERO;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: per-cycle vector tables plus hand-built
// sequences, expected outputs queued at drive time and compared after each edge.
module tb_wave_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [2:0]  wr_func;
    logic [15:0] wr_dwell;
    logic [2:0]  cfg_last;
    logic        loop;
    logic        start;
    logic        stop;
    logic [7:0]  wave_in;
    logic [2:0]  func;
    logic [2:0]  cur_idx;
    logic        busy;
    logic        step;
    logic        done;

    int checks   = 0;
    int failures = 0;
    logic ph = 1'b0;

    // expected record: {func, cur_idx, busy, step, done}
    typedef struct {
        logic        wr;
        logic [2:0]  wa;
        logic [2:0]  wf;
        logic [15:0] wd;
        logic [2:0]  cl;
        logic        lp;
        logic        st;
        logic        sp;
        logic [7:0]  wave;
        logic [8:0]  exp;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] exp_q[$];

    wave_sequencer #(.DWELL_W(16), .SYNC_TO(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_func(wr_func),
        .wr_dwell(wr_dwell), .cfg_last(cfg_last), .loop(loop), .start(start),
        .stop(stop), .wave_in(wave_in), .func(func), .cur_idx(cur_idx),
        .busy(busy), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] e(input logic [2:0] f, input logic [2:0] i,
                                     input logic b, input logic s, input logic d);
        return {f, i, b, s, d};
    endfunction

    function automatic vec_t mk(input logic wr, input logic [2:0] wa, input logic [2:0] wf,
                                input logic [15:0] wd, input logic [2:0] cl, input logic lp,
                                input logic st, input logic sp, input logic [7:0] wave,
                                input logic [8:0] ex);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wf = wf; v.wd = wd; v.cl = cl; v.lp = lp;
        v.st = st; v.sp = sp; v.wave = wave; v.exp = ex;
        return v;
    endfunction

    function automatic logic [7:0] tog();
        ph = ~ph;
        return ph ? 8'd200 : 8'd0;
    endfunction

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s got func=%b idx=%0d busy=%b step=%b done=%b exp func=%b idx=%0d busy=%b step=%b done=%b",
                     nm, act[8:6], act[5:3], act[2], act[1], act[0],
                     ex[8:6], ex[5:3], ex[2], ex[1], ex[0]);
        end
    endtask

    // Called at posedge+1: drive one cycle, queue the expectation, compare after the edge.
    task automatic cyc(input logic st, input logic sp, input logic [7:0] wave,
                       input logic [8:0] ex, input string nm);
        logic [8:0] got_exp;
        start   = st;
        stop    = sp;
        wave_in = wave;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        got_exp = exp_q.pop_front();
        check(nm, {func, cur_idx, busy, step, done}, got_exp);
    endtask

    task automatic set_wr(input logic [2:0] a, input logic [2:0] f, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_func = f; wr_dwell = d;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_func = '0; wr_dwell = '0;
        cfg_last = '0; loop = 1'b0; start = 1'b0; stop = 1'b0; wave_in = 8'd200;

        // single entry, restart with start held, stop during RUN
        vecs.push_back(mk(1, 0, 3'b011, 5, 0, 0, 0, 0, 200, e(3'b101, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 200, e(3'b011, 0, 1, 0, 0)));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 200, e(3'b011, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 200, e(3'b101, 0, 0, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 200, e(3'b011, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 200, e(3'b101, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 200, e(3'b101, 0, 0, 0, 0)));
        // crossing alignment and wrap
        vecs.push_back(mk(1, 0, 3'b001, 4, 1, 1, 0, 0, 200, e(3'b101, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 3'b010, 3, 1, 1, 0, 0, 200, e(3'b101, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 200, e(3'b001, 0, 1, 0, 0)));
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 200, e(3'b001, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 100, e(3'b010, 1, 1, 1, 0)));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 100, e(3'b010, 1, 1, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 200, e(3'b001, 0, 1, 1, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 200, e(3'b101, 0, 0, 0, 0)));

        repeat (2) @(posedge clk);
        #1;
        check("reset_held", {func, cur_idx, busy, step, done}, e(3'b101, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", {func, cur_idx, busy, step, done}, e(3'b101, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            if (vecs[i].wr) set_wr(vecs[i].wa, vecs[i].wf, vecs[i].wd);
            cfg_last = vecs[i].cl;
            loop     = vecs[i].lp;
            cyc(vecs[i].st, vecs[i].sp, vecs[i].wave, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // timeout: no crossing, ALIGN lasts SYNC_TO=8 cycles
        cfg_last = 3'd1; loop = 1'b1;
        cyc(0, 0, 0, e(3'b101, 0, 0, 0, 0), "to_idle");
        cyc(1, 0, 0, e(3'b001, 0, 1, 0, 0), "to_start");
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, e(3'b001, 0, 1, 0, 0), "to_run");
        for (int k = 0; k < 7; k++) cyc(0, 0, 0, e(3'b001, 0, 1, 0, 0), "to_align_wait");
        cyc(0, 0, 0, e(3'b010, 1, 1, 1, 0), "to_forced_step");
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, e(3'b010, 1, 1, 0, 0), "to_run1");
        cyc(0, 0, 0, e(3'b010, 1, 1, 0, 0), "to_align1");
        cyc(0, 1, 0, e(3'b101, 1, 0, 0, 0), "stop_in_align");
        for (int k = 0; k < 2; k++) cyc(0, 0, 0, e(3'b101, 1, 0, 0, 0), "after_stop");
        for (int k = 0; k < 2; k++) cyc(1, 1, 0, e(3'b101, 1, 0, 0, 0), "start_and_stop");

        // dwell 0 entry and live write to an entry not yet playing
        cfg_last = 3'd2; loop = 1'b0;
        set_wr(0, 3'b011, 3);  cyc(0, 0, tog(), e(3'b101, 1, 0, 0, 0), "lw_wr0");
        set_wr(1, 3'b001, 2);  cyc(0, 0, tog(), e(3'b101, 1, 0, 0, 0), "lw_wr1");
        set_wr(2, 3'b100, 0);  cyc(0, 0, tog(), e(3'b101, 1, 0, 0, 0), "lw_wr2");
        cyc(1, 0, tog(), e(3'b011, 0, 1, 0, 0), "lw_start");
        set_wr(1, 3'b000, 2);  cyc(0, 0, tog(), e(3'b011, 0, 1, 0, 0), "lw_live_write");
        cyc(0, 0, tog(), e(3'b011, 0, 1, 0, 0), "lw_run0");
        cyc(0, 0, tog(), e(3'b011, 0, 1, 0, 0), "lw_end0");
        cyc(0, 0, tog(), e(3'b000, 1, 1, 1, 0), "lw_step_new_value");
        cyc(0, 0, tog(), e(3'b000, 1, 1, 0, 0), "lw_run1");
        cyc(0, 0, tog(), e(3'b000, 1, 1, 0, 0), "lw_end1");
        cyc(0, 0, tog(), e(3'b100, 2, 1, 1, 0), "lw_step_dwell0");
        cyc(0, 0, tog(), e(3'b101, 2, 0, 0, 1), "lw_dwell0_done");
        cyc(0, 0, tog(), e(3'b101, 2, 0, 0, 0), "lw_idle");

        // asynchronous reset mid-RUN clears outputs and playlist
        cfg_last = 3'd0; loop = 1'b0;
        cyc(1, 0, 0, e(3'b011, 0, 1, 0, 0), "ar_start");
        cyc(0, 0, 0, e(3'b011, 0, 1, 0, 0), "ar_run");
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_mid_run", {func, cur_idx, busy, step, done}, e(3'b101, 0, 0, 0, 0));
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ar_release", {func, cur_idx, busy, step, done}, e(3'b101, 0, 0, 0, 0));
        cyc(1, 0, 0, e(3'b101, 0, 1, 0, 0), "ar_cleared_entry");
        cyc(0, 0, 0, e(3'b101, 0, 0, 0, 1), "ar_cleared_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_sequencer.md
# wave_sequencer

Programmable controller that drives the 3-bit `func` select of the wave generator through a stored playlist of up to 8 entries, each a (waveform, dwell) pair. Each switch is deferred to a midscale crossing of the generator output, with a bounded timeout, so transitions avoid large output jumps. It sits between the lab's control logic (buttons/switches or host) and the waveGenerator instance, and owns its `func` input exclusively.

## Interface
- `DWELL_W`, 16: width of the per-entry dwell count, in clk cycles.
- `SYNC_TO`, 255: maximum cycles spent waiting for a midscale crossing before a forced switch.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  write playlist entry this cycle.
- `wr_addr`  in  3  entry index written.
- `wr_func`  in  3  waveform code stored (000 rhomboid, 001 sine, 010 square, 011 triangle, 100 sawtooth, 101 zero).
- `wr_dwell`  in  DWELL_W  dwell stored; 0 is treated as 1.
- `cfg_last`  in  3  index of the last playlist entry.
- `loop`  in  1  1 = wrap from `cfg_last` to entry 0; 0 = finish after `cfg_last`.
- `start`  in  1  begin playback from entry 0 (level, sampled in IDLE).
- `stop`  in  1  abort playback.
- `wave_in`  in  8  current waveGenerator output sample.
- `func`  out  3  registered waveform select to waveGenerator.
- `cur_idx`  out  3  index of the entry currently driving `func`.
- `busy`  out  1  high in RUN or ALIGN.
- `step`  out  1  one-cycle pulse when `func` advances to a new entry.
- `done`  out  1  one-cycle pulse on normal end of a non-looping playlist.

## Operation
- Playlist: 8 registers {func[2:0], dwell[DWELL_W-1:0]}; reset to {101, 0}. Writes are accepted in any state. A write and a load of the same entry in the same cycle loads the old value.
- Reset values: state IDLE, `func`=101, `cur_idx`=0, `busy`=0, `step`=0, `done`=0, dwell counter 0, timeout counter 0, `msb_q`=0.
- `msb_q` registers `wave_in[7]` every cycle. A crossing is `wave_in[7] != msb_q`.
- IDLE: `func` held at 101. If `start` is high and `stop` is low, load entry 0: `func`←table[0].func, `cur_idx`←0, counter←max(dwell,1), go to RUN. `step` is not pulsed for the initial load.
- RUN: the counter decrements each cycle. In the cycle where counter==1:
  - If `cur_idx`==`cfg_last` and `loop`==0: go to IDLE, `func`←101, pulse `done`.
  - Otherwise go to ALIGN with the timeout counter cleared.
- ALIGN: `func` is unchanged. Each cycle, if a crossing occurs or the timeout counter == SYNC_TO-1, load the next entry: next = (`cur_idx`==`cfg_last`) ? 0 : `cur_idx`+1. Update `func` and `cur_idx`, reload the counter, pulse `step`, go to RUN. Otherwise increment the timeout counter.
- `stop` (any state, highest priority): next state IDLE, `func`←101, `busy`←0, no `done`.
- `cfg_last` and `loop` are sampled only at the end-of-entry decision. If `cur_idx` > `cfg_last` at that point, the next entry is 0, or the sequencer finishes when `loop`=0.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `start` sampled at edge N: `func`=table[0].func and `busy`=1 from edge N onward.
- An entry with dwell D holds `func` for D cycles in RUN plus A ALIGN cycles, with 1 ≤ A ≤ SYNC_TO.
- The `step` pulse is coincident with the new `func`/`cur_idx` values (same edge).
- `done` and `busy`=0 are asserted on the same edge as `func`→101.
- `stop` sampled at edge N: `func`=101 and `busy`=0 after edge N.
- `start` held high after `done` restarts playback on the next edge.
- Asynchronous `rst` mid-playback immediately forces all reset values. The playlist is also cleared.

## Test plan
- Reset: deassert `rst` → `func`=101, `busy`=0, `cur_idx`=0, `step`=`done`=0. Assert `rst` mid-RUN → same values immediately.
- Single entry: table[0]={011,5}, `cfg_last`=0, `loop`=0, `start` pulse → `func`=011 for exactly 5 cycles, then `func`=101 with a 1-cycle `done`, `busy`=0.
- Crossing alignment: table[0]={001,4}, table[1]={010,3}, `cfg_last`=1, `loop`=1. Drive `wave_in` 200 until 3 cycles after dwell expiry, then 100 → `step` on the crossing edge, `func`=010, `cur_idx`=1. After entry 1, wraps to `cur_idx`=0.
- Timeout: `SYNC_TO`=8, `wave_in` held at 0 → ALIGN lasts exactly 8 cycles, then forced `step`.
- Stop priority: `start` and `stop` both high in IDLE → stays IDLE. `stop` during ALIGN → `func`=101 next edge, no `done`, no `step`.
- Dwell 0 and live write: table[2]={100,0} → held 1 RUN cycle. Write table[1] while entry 0 plays → new value is used when entry 1 loads.
